// File: rtl/addmul_issue_ctrl_if.sv
// Bundle of the issue, unit-side and result-side signals of addmul_issue_ctrl.
// Ports: in_* operand packet (valid/ready), fu_* operands to / result from the
//        FP unit, out_* result stream (valid/ready), busy status.
interface addmul_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    // Upstream operand packet
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_opcode;
    logic             in_fmt;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;

    // FP add/mul unit side
    logic [1:0]       fu_opcode;
    logic             fu_fmt;
    logic [31:0]      fu_x;
    logic [31:0]      fu_y;
    logic [31:0]      fu_r;

    // Downstream result stream
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;

    // Status
    logic             busy;

    // Environment side: drives packets, the unit result and the consumer ready.
    modport master (
        output in_valid, in_opcode, in_fmt, in_x, in_y, in_tag,
        output fu_r, out_ready,
        input  in_ready, fu_opcode, fu_fmt, fu_x, fu_y,
        input  out_valid, out_r, out_tag, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, in_opcode, in_fmt, in_x, in_y, in_tag,
        input  fu_r, out_ready,
        output in_ready, fu_opcode, fu_fmt, fu_x, fu_y,
        output out_valid, out_r, out_tag, busy
    );
endinterface

// File: rtl/addmul_issue_ctrl.sv
// Purpose: issue/collect stage around a fixed-latency FP add/mul unit.
// Latency: accept edge E0 -> result visible on out_* after edge E0+LATENCY+1.
// Backpressure: credit-based; in_ready drops once every FIFO slot is reserved, in-flight results always land.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries
//   in_*   operand packet in (valid/ready), fields registered onto fu_*
//   fu_*   registered operands to the unit, fu_r result back from it
//   out_*  head of the result FIFO (valid/ready), strictly in issue order
//   busy   any packet held in issue register, shadow pipe or FIFO
module addmul_issue_ctrl #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    addmul_issue_ctrl_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // Wide enough for the worst-case sum of all occupancy sources.
    localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 2);

    typedef struct packed {
        logic [31:0]      r;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             issue_vld_q, issue_vld_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
    logic [1:0]       fu_opcode_q, fu_opcode_d;
    logic             fu_fmt_q, fu_fmt_d;
    logic [31:0]      fu_x_q, fu_x_d;
    logic [31:0]      fu_y_q, fu_y_d;

    logic [LATENCY-1:0] sh_vld_q, sh_vld_d;
    logic [TAG_W-1:0]   sh_tag_q [LATENCY];
    logic [TAG_W-1:0]   sh_tag_d [LATENCY];

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Handshake and credit logic
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] occ;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    // Occupancy counts every packet that owns a FIFO slot: the one in the
    // issue register, those travelling through the unit, and those queued.
    // Only registered state feeds it, so a pop frees its credit one cycle
    // later and there is no out_ready -> in_ready path.
    always_comb begin
        occ = OCC_W'(issue_vld_q) + OCC_W'(cnt_q);
        for (int i = 0; i < LATENCY; i++) begin
            occ = occ + OCC_W'(sh_vld_q[i]);
        end
    end

    assign fifo_empty  = (cnt_q == '0);
    assign fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign in_ready_w  = rst_n && (occ < OCC_W'(FIFO_DEPTH));
    assign out_valid_w = !fifo_empty;
    assign accept      = bus.in_valid && in_ready_w;
    assign push        = sh_vld_q[LATENCY-1];
    assign pop         = out_valid_w && bus.out_ready;

    // Modulo increment so FIFO_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Issue register: operands are held when nothing is accepted; the unit
    // keeps computing on them but the cleared valid bit discards that slot.
    // ------------------------------------------------------------------
    always_comb begin
        issue_vld_d = accept;
        issue_tag_d = issue_tag_q;
        fu_opcode_d = fu_opcode_q;
        fu_fmt_d    = fu_fmt_q;
        fu_x_d      = fu_x_q;
        fu_y_d      = fu_y_q;
        if (accept) begin
            issue_tag_d = bus.in_tag;
            fu_opcode_d = bus.in_opcode;
            fu_fmt_d    = bus.in_fmt;
            fu_x_d      = bus.in_x;
            fu_y_d      = bus.in_y;
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipe: free-running, one stage per unit stage, so the last
    // stage is valid exactly when fu_r holds a result worth keeping.
    // ------------------------------------------------------------------
    always_comb begin
        sh_vld_d    = sh_vld_q;
        sh_tag_d    = sh_tag_q;
        sh_vld_d[0] = issue_vld_q;
        sh_tag_d[0] = issue_tag_q;
        for (int i = 1; i < LATENCY; i++) begin
            sh_vld_d[i] = sh_vld_q[i-1];
            sh_tag_d[i] = sh_tag_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO. Credits guarantee a free slot whenever push is set.
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q].r   = bus.fu_r;
            mem_d[wr_ptr_q].tag = sh_tag_q[LATENCY-1];
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Storage is cleared too so out_r/out_tag read 0 after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_vld_q <= 1'b0;
            issue_tag_q <= '0;
            fu_opcode_q <= '0;
            fu_fmt_q    <= 1'b0;
            fu_x_q      <= '0;
            fu_y_q      <= '0;
            sh_vld_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                sh_tag_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            issue_tag_q <= issue_tag_d;
            fu_opcode_q <= fu_opcode_d;
            fu_fmt_q    <= fu_fmt_d;
            fu_x_q      <= fu_x_d;
            fu_y_q      <= fu_y_d;
            sh_vld_q    <= sh_vld_d;
            sh_tag_q    <= sh_tag_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_w;
    assign bus.fu_opcode = fu_opcode_q;
    assign bus.fu_fmt    = fu_fmt_q;
    assign bus.fu_x      = fu_x_q;
    assign bus.fu_y      = fu_y_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_r     = mem_q[rd_ptr_q].r;
    assign bus.out_tag   = mem_q[rd_ptr_q].tag;
    assign bus.busy      = (occ != '0);

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && fifo_empty));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occ <= OCC_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_addmul_issue_ctrl.sv
// Bench for addmul_issue_ctrl: adder stub as the FP unit, a queue-based
// model checked every negedge, plus directed scenarios with literal checks.
module tb_addmul_issue_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int TW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    addmul_issue_ctrl_if #(.TAG_W(TW)) bus ();

    addmul_issue_ctrl #(
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH),
        .TAG_W     (TW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Unit stub: LAT-cycle pipelined X+Y
    logic [31:0] fu_pipe [LAT];
    always @(posedge clk) begin
        fu_pipe[0] <= bus.fu_x + bus.fu_y;
        for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
    end
    assign bus.fu_r = fu_pipe[LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: every accepted packet is outstanding until popped; it becomes
    // visible LAT+1 edges after its accept edge. Credits == outstanding.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0]   r;
        logic [TW-1:0] tag;
        int            land;
    } item_t;

    item_t       mq[$];
    int          edge_n = 0;
    logic [1:0]  e_op;
    logic        e_fmt;
    logic [31:0] e_x, e_y;
    bit          ev, er;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        e_op = '0; e_fmt = 1'b0; e_x = '0; e_y = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                e_op = '0; e_fmt = 1'b0; e_x = '0; e_y = '0;
                chk("rst in_ready",  32'(bus.in_ready),  0);
                chk("rst out_valid", 32'(bus.out_valid), 0);
                chk("rst busy",      32'(bus.busy),      0);
                chk("rst fu_x",      bus.fu_x,           0);
                chk("rst fu_y",      bus.fu_y,           0);
                chk("rst fu_op",     32'(bus.fu_opcode), 0);
                chk("rst fu_fmt",    32'(bus.fu_fmt),    0);
                chk("rst out_r",     bus.out_r,          0);
                chk("rst out_tag",   32'(bus.out_tag),   0);
            end else begin
                ev = (mq.size() > 0) && (mq[0].land <= edge_n);
                er = (mq.size() < DEPTH);
                chk("in_ready",  32'(bus.in_ready),  32'(er));
                chk("out_valid", 32'(bus.out_valid), 32'(ev));
                chk("busy",      32'(bus.busy),      32'(mq.size() != 0));
                chk("fu_x",      bus.fu_x,           e_x);
                chk("fu_y",      bus.fu_y,           e_y);
                chk("fu_opcode", 32'(bus.fu_opcode), 32'(e_op));
                chk("fu_fmt",    32'(bus.fu_fmt),    32'(e_fmt));
                if (ev) begin
                    chk("out_r",   bus.out_r,         mq[0].r);
                    chk("out_tag", 32'(bus.out_tag),  32'(mq[0].tag));
                    if (bus.out_ready) void'(mq.pop_front());
                end
                if (bus.in_valid && er) begin
                    mq.push_back('{r: bus.in_x + bus.in_y, tag: bus.in_tag,
                                   land: edge_n + LAT + 2});
                    e_op = bus.in_opcode; e_fmt = bus.in_fmt;
                    e_x  = bus.in_x;      e_y   = bus.in_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int seq = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present packet number seq (held until accepted), advance one edge.
    task automatic drive(input bit v, output bit acc);
        bus.in_valid  = v;
        bus.in_x      = 32'(seq * 17 + 3);
        bus.in_y      = 32'(seq * 5 + 1);
        bus.in_tag    = TW'(seq);
        bus.in_opcode = 2'(seq);
        bus.in_fmt    = seq[0];
        acc = v && bus.in_ready;
        step();
        if (acc) seq++;
    endtask

    initial begin
        bit acc;
        int n, stalls, nout, first, last, accepts, stale;

        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_fmt = 1'b0;
        bus.in_x = '0; bus.in_y = '0; bus.in_tag = '0; bus.out_ready = 1'b0;

        // Reset and idle
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("idle in_ready",  32'(bus.in_ready),  1);
        chk("idle out_valid", 32'(bus.out_valid), 0);
        chk("idle busy",      32'(bus.busy),      0);
        chk("idle fu_x",      bus.fu_x,           0);

        // Single op: 5+7 tag 3
        bus.in_valid = 1'b1; bus.in_x = 32'd5; bus.in_y = 32'd7;
        bus.in_tag = 4'd3; bus.in_opcode = 2'b01; bus.in_fmt = 1'b1;
        chk("single in_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("single latency", 32'(n), 4);
        chk("single out_r",   bus.out_r, 32'd12);
        chk("single out_tag", 32'(bus.out_tag), 3);
        chk("single fu_x held", bus.fu_x, 32'd5);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("single busy after pop",  32'(bus.busy),      0);
        chk("single valid after pop", 32'(bus.out_valid), 0);

        // Streaming: 20 back-to-back, consumer always ready
        bus.out_ready = 1'b1;
        seq = 0; stalls = 0; nout = 0; first = -1; last = -1;
        for (int k = 0; k < 32; k++) begin
            drive(seq < 20, acc);
            if (k < 20 && !acc) stalls++;
            if (bus.out_valid) begin
                nout++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("stream stalls",  32'(stalls), 0);
        chk("stream results", 32'(nout), 20);
        chk("stream span",    32'(last - first), 19);
        chk("stream busy",    32'(bus.busy), 0);

        // Backpressure: fill all credits, then drain with wrap
        bus.out_ready = 1'b0;
        accepts = 0;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, acc);
            if (acc) accepts++;
        end
        chk("bp accepts",   32'(accepts), 8);
        chk("bp in_ready",  32'(bus.in_ready), 0);
        chk("bp out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        chk("bp no comb ready", 32'(bus.in_ready), 0);
        drive(1'b1, acc);
        chk("bp ready after pop", 32'(bus.in_ready), 1);
        for (int k = 0; k < 16; k++) drive(1'b1, acc);
        for (int k = 0; k < 14; k++) drive(1'b0, acc);
        chk("bp drained", 32'(bus.busy), 0);

        // Reset with 3 queued and 2 in the shadow pipe
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'b1, acc);
        drive(1'b0, acc);
        drive(1'b0, acc);
        chk("mid out_valid before rst", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid out_valid in rst", 32'(bus.out_valid), 0);
        chk("mid busy in rst",      32'(bus.busy), 0);
        step();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.out_valid) stale++;
        end
        chk("mid no stale", 32'(stale), 0);
        chk("mid in_ready", 32'(bus.in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addmul_issue_ctrl.md
Name: addmul_issue_ctrl

Overview:
- Valid/ready issue and result-collection stage wrapped around the fixed-latency FP add/mul unit (including its retiming-pipe variant).
- Upstream, it accepts operand packets and registers them onto the unit's operand inputs.
- In parallel, it tracks each issued packet with a valid/tag shadow pipeline matched to the unit's latency.
- Downstream, it captures each result into a credit-protected FIFO, so backpressure never drops an in-flight result.

Parameters:
- LATENCY, 3: cycles from operands present on fu_* to result on fu_r; must equal the unit's total latency including retiming stages; >=1.
- FIFO_DEPTH, 8: result FIFO entries; >=2; full throughput requires FIFO_DEPTH >= LATENCY+2.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand packet valid
- in_ready  out  1  block accepts packet this cycle
- in_opcode  in  2  operation select, passed to unit unmodified
- in_fmt  in  1  format select, passed to unit unmodified
- in_x  in  32  operand X
- in_y  in  32  operand Y
- in_tag  in  TAG_W  sideband tag, returned with the result
- fu_opcode  out  2  registered opcode to unit
- fu_fmt  out  1  registered fmt to unit
- fu_x  out  32  registered X to unit
- fu_y  out  32  registered Y to unit
- fu_r  in  32  unit result
- out_valid  out  1  result FIFO non-empty
- out_ready  in  1  consumer takes head entry
- out_r  out  32  head result
- out_tag  out  TAG_W  head tag
- busy  out  1  any packet in issue register, shadow pipe, or FIFO

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Clears the issue-valid bit, all shadow-valid bits, FIFO pointers, and the FIFO count.
  - fu_opcode, fu_fmt, fu_x, fu_y, out_r, and out_tag go to 0.
  - out_valid=0, busy=0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-operation discards every in-flight and queued result; no partial output after release.
- Accept: a packet is accepted at edge E0 when in_valid && in_ready. Between E0 and E1, fu_* hold its fields and the issue-valid bit is 1.
- Hold: with no accept, fu_* keep their previous values and issue-valid=0. The unit runs free; its output in that slot is discarded.
- Shadow pipe: LATENCY-stage shift register of {valid, tag}, advancing every cycle (never stalls).
  - Stage 0 loads {issue_valid, issue_tag}.
  - The last stage lines up with fu_r: a packet issued between E0 and E1 has its result sampled at edge E(LATENCY+1).
- Capture: at the edge where the last shadow stage is valid, {fu_r, tag} is pushed into the FIFO.
  - out_valid rises after that edge, so the minimum in-to-out latency is LATENCY+1 edges after acceptance.
  - There is no bypass path around the FIFO.
- Credits:
  - occ = issue_valid + count of valid shadow stages + FIFO count.
  - in_ready = (occ < FIFO_DEPTH) && rst_n.
  - Pop in the current cycle does not raise in_ready (no combinational out_ready->in_ready path).
  - This guarantees the FIFO never overflows.
- Output:
  - Pop at an edge with out_valid && out_ready.
  - out_r and out_tag show the head entry combinationally from FIFO storage.
  - Results leave strictly in issue order.
  - out_r and out_tag are stable while out_valid && !out_ready.
- Simultaneous push and pop: the count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two.
- Full FIFO with out_ready=0: in_ready stays low once occ reaches FIFO_DEPTH. In-flight results still land, because credits reserved their slots.
- busy = (occ != 0).
- Assertions (simulation only):
  - No push when the FIFO is full.
  - No pop when the FIFO is empty.
  - occ <= FIFO_DEPTH.

Test Plan:
- Reset release, idle: in_ready=1 one cycle after rst_n rises; out_valid=0; busy=0; fu_* = 0.
- Single op (LATENCY=3, fu stub returns X+Y): accept X=5, Y=7, tag=3 at E0 -> push at E4; out_valid=1 after E4 with out_r=12, out_tag=3; popped with out_ready=1; busy=0 after the pop.
- Streaming: 20 back-to-back ops with out_ready=1 and FIFO_DEPTH=8 -> in_ready never drops; 20 results in order with tags 0..19; one result per cycle after the initial latency.
- Backpressure: out_ready=0 while in_valid=1 -> exactly 8 accepts, then in_ready=0; FIFO holds 8 with no loss. Raising out_ready drains tags in order, and in_ready returns the cycle after the first pop.
- Simultaneous push/pop at count=FIFO_DEPTH-1 with wrap across index 7->0 -> count constant; data and tags correct across the wrap.
- Reset mid-flight: assert rst_n=0 with 2 ops in the shadow pipe and 3 in the FIFO -> out_valid=0 immediately; after release, no stale result ever appears on out_valid.
